// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Definitions shared by the branch direction predictor, the branch handler
// and their benches:
//   - ctr_state_e : 2-bit saturating counter encodings SNT/WNT/WT/ST
//   - BRANCH      : branch opcode value used by the handler
//   - DBITS_DEFAULT : default datapath/PC width
//   - bp_index()  : word-aligned PC to table index extraction
// ---------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,    // strongly not-taken
        WNT = 2'b01,    // weakly not-taken
        WT  = 2'b10,    // weakly taken
        ST  = 2'b11     // strongly taken
    } ctr_state_e;

    localparam logic [3:0] BRANCH        = 4'b0010;
    localparam int         DBITS_DEFAULT = 32;

    // The index helper works on a fixed wide PC so that any DBITS / IDX_BITS
    // combination up to these limits can share one function.
    localparam int PC_MAX_BITS  = 64;
    localparam int IDX_MAX_BITS = 16;

    // idx(pc) = pc[idx_bits+1:2]; the two byte-offset bits never select an entry.
    function automatic logic [IDX_MAX_BITS-1:0] bp_index(
        input logic [PC_MAX_BITS-1:0] pc,
        input int unsigned            idx_bits
    );
        logic [PC_MAX_BITS-1:0] mask;
        mask = (64'd1 << idx_bits) - 64'd1;
        return IDX_MAX_BITS'((pc >> 2) & mask);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// ---------------------------------------------------------------------------
// bp_sat_counter
// Combinational next-state of a 2-bit saturating direction counter.
// Ports:
//   cur   in  [1:0]  current counter value
//   taken in         resolved outcome (1 = taken)
//   nxt   out [1:0]  counter moved one step toward the outcome, no wrap
// ---------------------------------------------------------------------------
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Bimodal direction predictor: a table of 2^IDX_BITS 2-bit saturating
// counters indexed by word-aligned PC bits. Lookup for fetch is a
// combinational read of the registered table; training from EX lands at the
// clock edge, so a same-cycle lookup of the trained entry sees the old value.
//
// Ports:
//   clk         in            rising-edge clock
//   reset       in            synchronous active-high reset (table -> INIT_STATE)
//   IF_PC       in  [DBITS]   PC being fetched
//   prediction  out           predicted direction for IF_PC (1 = taken)
//   update      in            one-cycle strobe: a branch resolved in EX
//   EX_PC       in  [DBITS]   PC of the resolving branch
//   EX_taken    in            actual outcome
//   EX_pred     in            prediction that was made for that branch
//   mispredict  out           registered pulse: last-cycle update mispredicted
//   branch_cnt  out [32]      (BP_PERF_CNT_EN only) saturating update count
//   mispred_cnt out [32]      (BP_PERF_CNT_EN only) saturating mispredict count
//
// Optional feature macro: BP_PERF_CNT_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         DBITS      = DBITS_DEFAULT,
    parameter int         IDX_BITS   = 6,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] IF_PC,
    output logic             prediction,
    input  logic             update,
    input  logic [DBITS-1:0] EX_PC,
    input  logic             EX_taken,
    input  logic             EX_pred,
`ifdef BP_PERF_CNT_EN
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt,
`endif
    output logic             mispredict
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // ---------------- index extraction ----------------
    logic [PC_MAX_BITS-1:0]  if_pc_ext;
    logic [PC_MAX_BITS-1:0]  ex_pc_ext;
    logic [IDX_MAX_BITS-1:0] if_idx_full;
    logic [IDX_MAX_BITS-1:0] ex_idx_full;
    logic [IDX_BITS-1:0]     if_idx;
    logic [IDX_BITS-1:0]     ex_idx;

    assign if_pc_ext   = PC_MAX_BITS'(IF_PC);
    assign ex_pc_ext   = PC_MAX_BITS'(EX_PC);
    assign if_idx_full = bp_index(if_pc_ext, IDX_BITS);
    assign ex_idx_full = bp_index(ex_pc_ext, IDX_BITS);
    assign if_idx      = if_idx_full[IDX_BITS-1:0];
    assign ex_idx      = ex_idx_full[IDX_BITS-1:0];

    // Upper index bits are always zero; only the low IDX_BITS are meaningful.
    logic unused_idx_bits;
    assign unused_idx_bits = ^{if_idx_full, ex_idx_full};

    // ---------------- counter table ----------------
    logic [1:0] ctr_vec [ENTRIES];
    logic [1:0] ctr_cur;
    logic [1:0] ctr_nxt;

    // A single next-state calculator serves the one entry being trained.
    assign ctr_cur = ctr_vec[ex_idx];

    bp_sat_counter u_sat_counter (
        .cur   (ctr_cur),
        .taken (EX_taken),
        .nxt   (ctr_nxt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [1:0] ctr_q;
            logic [1:0] ctr_d;
            logic       wr_en;

            // The && keeps an unknown EX_PC from reaching any entry while
            // update is low.
            assign wr_en = update && (ex_idx == IDX_BITS'(gi));

            always_comb begin
                ctr_d = ctr_q;
                if (wr_en) begin
                    ctr_d = ctr_nxt;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ctr_q <= INIT_STATE;
                end else begin
                    ctr_q <= ctr_d;
                end
            end

            assign ctr_vec[gi] = ctr_q;
        end
    endgenerate

    // No bypass: the lookup reads registered state only.
    assign prediction = ctr_vec[if_idx][1];

    // ---------------- mispredict pulse ----------------
    logic mispredict_q;
    logic mispredict_d;

    always_comb begin
        mispredict_d = update & (EX_taken ^ EX_pred);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_q <= 1'b0;
        end else begin
            mispredict_q <= mispredict_d;
        end
    end

    assign mispredict = mispredict_q;

`ifdef BP_PERF_CNT_EN
    // ---------------- performance counters ----------------
    logic [31:0] branch_cnt_q;
    logic [31:0] branch_cnt_d;
    logic [31:0] mispred_cnt_q;
    logic [31:0] mispred_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (update && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (update && (EX_taken ^ EX_pred) && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direction predictor for the pipelined core. Its `prediction` output drives the prediction input of the branch handler.
- Consumes the handler's `update` strobe and the resolved branch outcome from EX to train a table of 2-bit saturating counters.
- Indexed by word-aligned PC bits. Lookup serves the fetch stage in the same cycle; training happens in EX one cycle later in effect.

Parameters:
- DBITS, 32, datapath/PC width.
- IDX_BITS, 6, log2 of table entries (64 entries).
- INIT_STATE, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- IF_PC  input  DBITS  PC of the instruction being fetched.
- prediction  output  1  predicted direction for IF_PC (1 = taken).
- update  input  1  one-cycle strobe from the branch handler: a branch resolved in EX.
- EX_PC  input  DBITS  PC of the resolving branch.
- EX_taken  input  1  actual outcome (the handler's condFlag).
- EX_pred  input  1  prediction that was made for this branch, piped down with it.
- mispredict  output  1  registered; high the cycle after an update where EX_taken != EX_pred.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous, active-high. On reset, all 2^IDX_BITS counters are set to INIT_STATE and `mispredict` is set to 0.
- Indexing: idx(pc) = pc[IDX_BITS+1:2]; PC bits [1:0] are ignored. Aliasing between PCs that share an index is accepted.
- Counter encoding:
  - 00 SNT (strongly not-taken)
  - 01 WNT (weakly not-taken)
  - 10 WT (weakly taken)
  - 11 ST (strongly taken)
- Lookup: `prediction` = table[idx(IF_PC)][1]. Combinational read of registered state, zero-cycle latency.
- Update: when `update` = 1 at a rising edge, table[idx(EX_PC)] moves toward EX_taken by one step:
  - taken: 00→01→10→11, and 11 stays 11.
  - not taken: 11→10→01→00, and 00 stays 00.
  - No wrap-around.
  - When `update` = 0, the table holds.
- Same-index collision: if the lookup index equals the update index in the same cycle, `prediction` reflects the pre-update value. There is no bypass; the new value is visible from the next cycle.
- mispredict: registered `update & (EX_taken ^ EX_pred)`. It is a one-cycle pulse and is 0 whenever `update` was 0 in the previous cycle.
- Reset with update: `reset` and `update` high together → reset wins, and all entries go to INIT_STATE.
- Reset during operation: all training history is lost. There is no partial-reset behaviour.
- X/unknown on EX_PC while `update` = 0 must not disturb any state.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- When defined, add two outputs:
  - `branch_cnt [31:0]`: increments on every `update`.
  - `mispred_cnt [31:0]`: increments on every update with EX_taken != EX_pred.
- Both counters are cleared by `reset` and saturate at 32'hFFFFFFFF (no wrap).
- When undefined, these ports and their registers are absent, and all other behaviour is identical.

Decomposition:
- Shared package `bp_pkg`:
  - counter state constants SNT/WNT/WT/ST.
  - opcode constant BRANCH = 4'b0010 (shared with the branch handler and its bench).
  - DBITS default.
  - index-extraction function.
- Sub-module `bp_sat_counter`: combinational 2-bit saturating next-state (inputs: cur, taken; output: nxt), instantiated once in the update path.

Test Plan:
- Reset → lookup any PC → prediction = 0, all entries = 01, mispredict = 0.
- PC 0x8, three updates taken (EX_pred = 0, 1, 1) → entry 01→10→11→11. Prediction = 1 from the cycle after the first update. mispredict pulses only after the first update.
- After saturating at 11, one not-taken update → entry = 10, prediction stays 1. A second not-taken update → 01, prediction = 0.
- IF_PC = EX_PC = 0x10, entry 01, update taken → prediction = 0 in the update cycle and 1 in the next cycle (no bypass).
- PCs 0x4 and 0x104 (same idx with IDX_BITS = 6) → training 0x4 changes the prediction for 0x104. PC 0x8 is unaffected.
- With BP_PERF_CNT_EN defined: 5 updates, 2 of them mispredicted → branch_cnt = 5, mispred_cnt = 2. Reset asserted together with an update → both counters = 0 and all entries = 01.
